// File: rtl/ripple_count_capture.sv
// Brings a free-running ripple count bus into the clk domain and filters out
// settle-time transients. Accepted steps add up into a wide total that a
// valid/ready snapshot port can capture.
module ripple_count_capture #(
  parameter int CNT_W  = 2,
  parameter int ACC_W  = 16,
  parameter int STABLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             clr,
  input  logic             snap_req,
  input  logic             snap_ready,
  output logic             snap_valid,
  output logic [ACC_W-1:0] snap_data,
  output logic [ACC_W-1:0] acc,
  output logic [CNT_W-1:0] stable_cnt,
  output logic             ovf,
  output logic [7:0]       glitch_cnt
);

  localparam int HOLD_W = $clog2(STABLE + 1);

  typedef enum logic {
    IDLE,
    HOLD
  } snapState_t;

  logic [CNT_W-1:0]  sync1_q, sync2_q;
  logic [CNT_W-1:0]  stable_q, stable_d;
  logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        glitch_q, glitch_d;
  snapState_t        state_q, state_d;
  logic              snapValid_q, snapValid_d;
  logic [ACC_W-1:0]  snapData_q, snapData_d;

  logic              sameSample;
  logic              accept;
  logic [CNT_W-1:0]  deltaEff;
  logic [ACC_W:0]    sum;

  // sync2 keeps its value at this edge whenever sync1 already matches it,
  // so holdCnt counts how many edges sync2 has shown the same code.
  always_comb begin
    sameSample = (sync1_q == sync2_q);
    holdCnt_d  = holdCnt_q;
    if (!sameSample) begin
      holdCnt_d = HOLD_W'(1);
    end else if (holdCnt_q < HOLD_W'(STABLE)) begin
      holdCnt_d = holdCnt_q + 1'b1;
    end
    accept   = sameSample && (holdCnt_q >= HOLD_W'(STABLE - 1));
    deltaEff = accept ? (sync2_q - stable_q) : '0;
    stable_d = accept ? sync2_q : stable_q;
  end

  always_comb begin
    sum = {1'b0, acc_q} + (ACC_W + 1)'(deltaEff);
    if (clr) begin
      acc_d = ACC_W'(deltaEff);
      ovf_d = 1'b0;
    end else begin
      acc_d = sum[ACC_W-1:0];
      ovf_d = ovf_q | sum[ACC_W];
    end
  end

  // A code that leaves sync2 while differing from the accepted baseline was
  // never accepted, since acceptance makes it the baseline.
  always_comb begin
    glitch_d = glitch_q;
    if (!sameSample && (sync2_q != stable_q) && (glitch_q != 8'hFF)) begin
      glitch_d = glitch_q + 8'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    snapValid_d = snapValid_q;
    snapData_d  = snapData_q;
    case (state_q)
      IDLE: begin
        if (snap_req) begin
          snapData_d  = acc_q;
          snapValid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (snap_ready) begin
          snapValid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        snapValid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      holdCnt_q   <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      glitch_q    <= '0;
      state_q     <= IDLE;
      snapValid_q <= 1'b0;
      snapData_q  <= '0;
    end else begin
      sync1_q     <= cnt_in;
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      holdCnt_q   <= holdCnt_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      glitch_q    <= glitch_d;
      state_q     <= state_d;
      snapValid_q <= snapValid_d;
      snapData_q  <= snapData_d;
    end
  end

  assign snap_valid = snapValid_q;
  assign snap_data  = snapData_q;
  assign acc        = acc_q;
  assign stable_cnt = stable_q;
  assign ovf        = ovf_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_ripple_count_capture.sv
// Randomised and directed bench for ripple_count_capture, run on a 16-bit and
// a 4-bit accumulator instance driven by the same stimulus.
module tb_ripple_count_capture;

  localparam int CNT_W  = 2;
  localparam int STABLE = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cntIn;
  logic        clr, snapReq, snapReady;

  logic        snapValid16, ovf16;
  logic [15:0] snapData16, acc16;
  logic [1:0]  stable16;
  logic [7:0]  glitch16;
  logic        snapValid4, ovf4;
  logic [3:0]  snapData4, acc4;
  logic [1:0]  stable4;
  logic [7:0]  glitch4;

  int checks = 0;
  int errors = 0;

  // Reference state: total of accepted deltas since the last clear; the
  // per-width acc/ovf values are derived from it arithmetically.
  int sinceClr, stableM, glitchM, snapValM;
  bit holdM;
  int hist[$];

  always #5 clk = ~clk;

  ripple_count_capture #(.CNT_W(CNT_W), .ACC_W(16), .STABLE(STABLE)) dut16 (
    .clk(clk), .rst(rst), .cnt_in(cntIn), .clr(clr), .snap_req(snapReq),
    .snap_ready(snapReady), .snap_valid(snapValid16), .snap_data(snapData16),
    .acc(acc16), .stable_cnt(stable16), .ovf(ovf16), .glitch_cnt(glitch16)
  );

  ripple_count_capture #(.CNT_W(CNT_W), .ACC_W(4), .STABLE(STABLE)) dut4 (
    .clk(clk), .rst(rst), .cnt_in(cntIn), .clr(clr), .snap_req(snapReq),
    .snap_ready(snapReady), .snap_valid(snapValid4), .snap_data(snapData4),
    .acc(acc4), .stable_cnt(stable4), .ovf(ovf4), .glitch_cnt(glitch4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    sinceClr = 0;
    stableM  = 0;
    glitchM  = 0;
    snapValM = 0;
    holdM    = 1'b0;
    hist     = {};
    for (int i = 0; i < STABLE; i++) hist.push_back(0);
  endtask

  // hist holds the cnt_in samples of the previous STABLE edges; a code is
  // accepted once it filled that whole window.
  task automatic modelEdge();
    int  v;
    int  delta;
    bit  ok;
    v  = hist[$];
    ok = 1'b1;
    for (int i = 0; i < STABLE; i++) if (hist[hist.size() - 1 - i] != v) ok = 1'b0;
    delta = ok ? ((v - stableM) & ((1 << CNT_W) - 1)) : 0;
    if (hist[$] != hist[$-1] && hist[$-1] != stableM && glitchM < 255) glitchM++;
    if (!holdM && snapReq) begin
      snapValM = sinceClr;
      holdM    = 1'b1;
    end else if (holdM && snapReady) begin
      holdM = 1'b0;
    end
    if (clr) sinceClr = delta;
    else     sinceClr = sinceClr + delta;
    if (ok) stableM = v;
    hist.push_back(int'(cntIn));
    void'(hist.pop_front());
  endtask

  task automatic checkAll();
    checkOutput("acc16",   32'(acc16),       32'(sinceClr % 65536));
    checkOutput("ovf16",   32'(ovf16),       32'(sinceClr >= 65536));
    checkOutput("acc4",    32'(acc4),        32'(sinceClr % 16));
    checkOutput("ovf4",    32'(ovf4),        32'(sinceClr >= 16));
    checkOutput("stab16",  32'(stable16),    32'(stableM));
    checkOutput("stab4",   32'(stable4),     32'(stableM));
    checkOutput("glit16",  32'(glitch16),    32'(glitchM));
    checkOutput("glit4",   32'(glitch4),     32'(glitchM));
    checkOutput("valid16", 32'(snapValid16), 32'(holdM));
    checkOutput("valid4",  32'(snapValid4),  32'(holdM));
    checkOutput("sdata16", 32'(snapData16),  32'(snapValM % 65536));
    checkOutput("sdata4",  32'(snapData4),   32'(snapValM % 16));
  endtask

  // Called at a falling edge: drive inputs, step one rising edge, check.
  task automatic applyStimulus(input logic [1:0] cnt, input logic c,
                               input logic req, input logic rdy);
    cntIn     = cnt;
    clr       = c;
    snapReq   = req;
    snapReady = rdy;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkAll();
  endtask

  task automatic holdValue(input logic [1:0] v, input int n);
    for (int i = 0; i < n; i++) applyStimulus(v, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [1:0] stepSeq [6];
    int         len;
    logic [1:0] v;
    stepSeq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    rst = 1'b1; cntIn = '0; clr = 1'b0; snapReq = 1'b0; snapReady = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkAll();

    foreach (stepSeq[i]) holdValue(stepSeq[i], 8);
    checkOutput("wrapAcc", 32'(acc16), 32'd5);
    checkOutput("wrapStab", 32'(stable16), 32'd1);
    checkOutput("wrapGlit", 32'(glitch16), 32'd0);

    holdValue(2'd0, 1);
    holdValue(2'd3, 8);
    checkOutput("rippleAcc", 32'(acc16), 32'd7);
    checkOutput("rippleGlit", 32'(glitch16), 32'd1);

    applyStimulus(2'd3, 1'b0, 1'b1, 1'b0);
    applyStimulus(2'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(2'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("snapHeld", 32'(snapData16), 32'd7);
    checkOutput("snapValid", 32'(snapValid16), 32'd1);
    checkOutput("snapLiveAcc", 32'(acc16), 32'd8);
    applyStimulus(2'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("snapDrop", 32'(snapValid16), 32'd0);
    holdValue(2'd0, 2);

    holdValue(2'd1, 8);
    holdValue(2'd0, 8);
    checkOutput("skipAcc", 32'(acc16), 32'd12);

    applyStimulus(2'd0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 15; k++) holdValue(2'(k % 4), 4);
    holdValue(2'd1, 6);
    checkOutput("ovfAcc4", 32'(acc4), 32'd1);
    checkOutput("ovfFlag4", 32'(ovf4), 32'd1);
    checkOutput("ovfFlag16", 32'(ovf16), 32'd0);
    applyStimulus(2'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'd2, 1'b1, 1'b0, 1'b0);
    checkOutput("clrAcc4", 32'(acc4), 32'd1);
    checkOutput("clrOvf4", 32'(ovf4), 32'd0);
    checkOutput("clrAcc16", 32'(acc16), 32'd1);

    len = 0;
    while (len < 400) begin
      int n;
      v = 2'($urandom_range(0, 3));
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        applyStimulus(v, 1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 5) == 0),
                      1'($urandom_range(0, 2) != 0));
      end
      len += n;
    end

    holdValue(2'd0, 4);
    for (int i = 0; i < 300; i++) holdValue((i % 2 == 0) ? 2'd1 : 2'd2, 1);
    checkOutput("glitchSat", 32'(glitch16), 32'd255);

    holdValue(2'd1, 4);
    applyStimulus(2'd1, 1'b0, 1'b1, 1'b0);
    checkOutput("preRstValid", 32'(snapValid16), 32'd1);
    #2;
    rst   = 1'b1;
    cntIn = 2'd0;
    #1;
    checkOutput("rstValid16", 32'(snapValid16), 32'd0);
    checkOutput("rstValid4", 32'(snapValid4), 32'd0);
    checkOutput("rstAcc16", 32'(acc16), 32'd0);
    checkOutput("rstData16", 32'(snapData16), 32'd0);
    checkOutput("rstStab16", 32'(stable16), 32'd0);
    checkOutput("rstGlit16", 32'(glitch16), 32'd0);
    checkOutput("rstOvf4", 32'(ovf4), 32'd0);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    holdValue(2'd0, 6);
    checkOutput("postRstAcc", 32'(acc16), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
